bc_control_unit: RTL and testbench

BC_CONTROL_UNIT -- requirements
Module: bc_control_unit

---
 rtl/bc_pkg.sv | 77 +++++++
 rtl/bc_control_unit_if.sv | 39 +++
 rtl/bc_decoder.sv | 64 ++++++
 rtl/bc_control_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_bc_control_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the basic-computer control unit.
// Contents:
//   stateE      - control FSM states (IND only exists with BC_INDIRECT_EN)
//   OP_*        - memory-reference opcodes plus the register-reference opcode
//   BUS_*       - common-bus source select encodings
//   ALU_*       - ALU operation encodings
//   LD_*/INC_*  - bit positions inside the ld and inc strobe vectors
//   regOpE      - register-reference micro-operation picked from ir[6:0]
// Configuration macro: BC_INDIRECT_EN (adds the IND state).
// ---------------------------------------------------------------------------
package bc_pkg;

   typedef enum logic [2:0] {
      ST_F0,
      ST_F1,
      ST_DEC,
`ifdef BC_INDIRECT_EN
      ST_IND,
`endif
      ST_RD,
      ST_EX1,
      ST_EX2,
      ST_HLT
   } stateE;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_REG = 3'd7;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   localparam logic [2:0] ALU_AND     = 3'd0;
   localparam logic [2:0] ALU_ADD     = 3'd1;
   localparam logic [2:0] ALU_PASS_DR = 3'd2;
   localparam logic [2:0] ALU_CMA     = 3'd3;

   localparam int LD_AR = 0;
   localparam int LD_PC = 1;
   localparam int LD_DR = 2;
   localparam int LD_AC = 3;
   localparam int LD_IR = 4;

   localparam int INC_AR = 0;
   localparam int INC_PC = 1;
   localparam int INC_DR = 2;
   localparam int INC_AC = 3;

   typedef enum logic [2:0] {
      RR_NOP,
      RR_HLT,
      RR_SZA,
      RR_SNA,
      RR_SPA,
      RR_INC,
      RR_CMA,
      RR_CLA
   } regOpE;

   // Opcodes that need their operand fetched from memory into DR before execute.
   function automatic logic isMemOperand(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA) || (op == OP_ISZ);
   endfunction

endpackage

// File: rtl/bc_control_unit_if.sv
// ---------------------------------------------------------------------------
// bc_control_unit_if
// Bundle between the control unit and the datapath/memory.
// Parameter: W - instruction/data width.
// Signals:
//   ir, mem_ready, ac_zero, ac_neg, dr_zero  - status into the control unit
//   mem_re, mem_we, ld[4:0], inc[3:0], clr_ac,
//   bus_sel[2:0], alu_op[2:0], halted         - control out of the control unit
// Modports: master (control unit side), slave (datapath side).
// ---------------------------------------------------------------------------
interface bc_control_unit_if #(
   parameter int W = 16
);

   logic [W-1:0] ir;
   logic         mem_ready;
   logic         ac_zero;
   logic         ac_neg;
   logic         dr_zero;
   logic         mem_re;
   logic         mem_we;
   logic [4:0]   ld;
   logic [3:0]   inc;
   logic         clr_ac;
   logic [2:0]   bus_sel;
   logic [2:0]   alu_op;
   logic         halted;

   modport master (
      input  ir, mem_ready, ac_zero, ac_neg, dr_zero,
      output mem_re, mem_we, ld, inc, clr_ac, bus_sel, alu_op, halted
   );

   modport slave (
      output ir, mem_ready, ac_zero, ac_neg, dr_zero,
      input  mem_re, mem_we, ld, inc, clr_ac, bus_sel, alu_op, halted
   );

endinterface

// File: rtl/bc_decoder.sv
// ---------------------------------------------------------------------------
// bc_decoder
// Purely combinational instruction-register decode for the control unit.
// Parameter: W - instruction width (I = ir[W-1], opcode = ir[W-2:W-4]).
// Ports:
//   i_ir          in  W  instruction register contents
//   o_opcode      out 3  opcode field
//   o_regRef      out 1  register-reference instruction (opcode 7, I = 0)
//   o_useInd      out 1  indirect cycle needed (only with BC_INDIRECT_EN)
//   o_memOperand  out 1  operand must be read into DR (AND/ADD/LDA/ISZ)
//   o_regOp       out 3  register-reference operation from highest set ir[6:0] bit
// Configuration macro: BC_INDIRECT_EN.
// ---------------------------------------------------------------------------
module bc_decoder
   import bc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] i_ir,
   output logic [2:0]   o_opcode,
   output logic         o_regRef,
`ifdef BC_INDIRECT_EN
   output logic         o_useInd,
`endif
   output logic         o_memOperand,
   output regOpE        o_regOp
);

   logic w_indirect;

   assign w_indirect   = i_ir[W-1];
   assign o_opcode     = i_ir[W-2:W-4];
   assign o_regRef     = (o_opcode == OP_REG) && !w_indirect;
   assign o_memOperand = isMemOperand(o_opcode);

`ifdef BC_INDIRECT_EN
   // Opcode 7 never goes indirect: with I=1 it is a plain NOP.
   assign o_useInd = w_indirect && (o_opcode != OP_REG);
`endif

   // The address bits between the opcode and the register-reference field are
   // consumed by the datapath, not by the controller.
   if (W > 11) begin : gUnusedIr
      logic w_unusedIr;
      assign w_unusedIr = ^i_ir[W-5:7];
   end

   // Only the highest set bit of ir[6:0] counts, so the casez is ordered from
   // bit 6 downward and lower bits are don't-cares once a higher one matches.
   always_comb begin
      o_regOp = RR_NOP;
      casez (i_ir[6:0])
         7'b1??????: o_regOp = RR_CLA;
         7'b01?????: o_regOp = RR_CMA;
         7'b001????: o_regOp = RR_INC;
         7'b0001???: o_regOp = RR_SPA;
         7'b00001??: o_regOp = RR_SNA;
         7'b000001?: o_regOp = RR_SZA;
         7'b0000001: o_regOp = RR_HLT;
         default:    o_regOp = RR_NOP;
      endcase
   end

endmodule

// File: rtl/bc_control_unit.sv
// ---------------------------------------------------------------------------
// bc_control_unit
// Hardwired control FSM of the basic computer: fetch, decode, optional
// indirect, operand read and execute, generating load/increment strobes,
// common-bus select, ALU op and memory requests for the datapath.
// Parameters:
//   W   - data/instruction width
//   AW  - address field width (must be <= W-4)
// Ports:
//   clk  in  1  clock, all state changes on the rising edge
//   rst  in  1  synchronous active-high reset; forces every output to 0
//   ctl  bc_control_unit_if.master
//        in : ir, mem_ready, ac_zero, ac_neg, dr_zero
//        out: mem_re, mem_we, ld{IR,AC,DR,PC,AR}, inc{AC,DR,PC,AR}, clr_ac,
//             bus_sel, alu_op, halted
// Configuration macro: BC_INDIRECT_EN - when defined, I=1 on opcodes 0-6
// inserts an IND state that reads the effective address into AR.
// ---------------------------------------------------------------------------
module bc_control_unit
   import bc_pkg::*;
#(
   parameter int W  = 16,
   parameter int AW = 12
) (
   input  logic clk,
   input  logic rst,
   bc_control_unit_if.master ctl
);

   if (AW > W - 4) begin : gAwCheck
      $error("bc_control_unit: AW must not exceed W-4");
   end

   stateE       r_state;
   logic [2:0]  w_opcode;
   logic        w_regRef;
   logic        w_memOperand;
   regOpE       w_regOp;
`ifdef BC_INDIRECT_EN
   logic        w_useInd;
`endif

   logic        w_memRe;
   logic        w_memWe;
   logic [4:0]  w_ld;
   logic [3:0]  w_inc;
   logic        w_clrAc;
   logic [2:0]  w_busSel;
   logic [2:0]  w_aluOp;
   logic        w_halted;

   bc_decoder #(.W(W)) uDecoder (
      .i_ir         (ctl.ir),
      .o_opcode     (w_opcode),
      .o_regRef     (w_regRef),
`ifdef BC_INDIRECT_EN
      .o_useInd     (w_useInd),
`endif
      .o_memOperand (w_memOperand),
      .o_regOp      (w_regOp)
   );

   // State register. Memory states (F1, IND, RD and the write phases of EX1/EX2)
   // only advance on mem_ready; everywhere else mem_ready is ignored. HLT is
   // left only through rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_F0;
      end else begin
         case (r_state)
            ST_F0: r_state <= ST_F1;
            ST_F1: begin
               if (ctl.mem_ready) r_state <= ST_DEC;
            end
            ST_DEC: begin
`ifdef BC_INDIRECT_EN
               if (w_useInd) r_state <= ST_IND;
               else
`endif
               if (w_memOperand) r_state <= ST_RD;
               else              r_state <= ST_EX1;
            end
`ifdef BC_INDIRECT_EN
            ST_IND: begin
               if (ctl.mem_ready) r_state <= w_memOperand ? ST_RD : ST_EX1;
            end
`endif
            ST_RD: begin
               if (ctl.mem_ready) r_state <= ST_EX1;
            end
            ST_EX1: begin
               if (w_regRef) begin
                  r_state <= (w_regOp == RR_HLT) ? ST_HLT : ST_F0;
               end else begin
                  case (w_opcode)
                     OP_STA: begin
                        if (ctl.mem_ready) r_state <= ST_F0;
                     end
                     OP_BSA: begin
                        if (ctl.mem_ready) r_state <= ST_EX2;
                     end
                     OP_ISZ:  r_state <= ST_EX2;
                     default: r_state <= ST_F0;
                  endcase
               end
            end
            ST_EX2: begin
               if (w_opcode == OP_ISZ) begin
                  if (ctl.mem_ready) r_state <= ST_F0;
               end else begin
                  r_state <= ST_F0;
               end
            end
            ST_HLT:  r_state <= ST_HLT;
            default: r_state <= ST_F0;
         endcase
      end
   end

   // Control outputs are a function of the current state plus the live IR,
   // flags and mem_ready so that completion strobes land in the same cycle as
   // mem_ready. Holding rst gates everything to zero, which also silences an
   // instruction that is aborted mid-flight.
   always_comb begin
      w_memRe  = 1'b0;
      w_memWe  = 1'b0;
      w_ld     = '0;
      w_inc    = '0;
      w_clrAc  = 1'b0;
      w_busSel = BUS_NONE;
      w_aluOp  = ALU_AND;
      w_halted = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_F0: begin
               w_ld[LD_AR] = 1'b1;
               w_busSel    = BUS_PC;
            end
            ST_F1: begin
               w_memRe  = 1'b1;
               w_busSel = BUS_MEM;
               if (ctl.mem_ready) begin
                  w_ld[LD_IR]   = 1'b1;
                  w_inc[INC_PC] = 1'b1;
               end
            end
            ST_DEC: begin
               w_ld[LD_AR] = 1'b1;
               w_busSel    = BUS_IR;
            end
`ifdef BC_INDIRECT_EN
            ST_IND: begin
               w_memRe  = 1'b1;
               w_busSel = BUS_MEM;
               if (ctl.mem_ready) w_ld[LD_AR] = 1'b1;
            end
`endif
            ST_RD: begin
               w_memRe  = 1'b1;
               w_busSel = BUS_MEM;
               if (ctl.mem_ready) w_ld[LD_DR] = 1'b1;
            end
            ST_EX1: begin
               if (w_regRef) begin
                  case (w_regOp)
                     RR_CLA: w_clrAc = 1'b1;
                     RR_CMA: begin
                        w_ld[LD_AC] = 1'b1;
                        w_aluOp     = ALU_CMA;
                     end
                     RR_INC: w_inc[INC_AC] = 1'b1;
                     RR_SPA: w_inc[INC_PC] = !ctl.ac_neg;
                     RR_SNA: w_inc[INC_PC] = ctl.ac_neg;
                     RR_SZA: w_inc[INC_PC] = ctl.ac_zero;
                     default: ;
                  endcase
               end else if (w_opcode != OP_REG) begin
                  case (w_opcode)
                     OP_AND: begin
                        w_ld[LD_AC] = 1'b1;
                        w_aluOp     = ALU_AND;
                     end
                     OP_ADD: begin
                        w_ld[LD_AC] = 1'b1;
                        w_aluOp     = ALU_ADD;
                     end
                     OP_LDA: begin
                        w_ld[LD_AC] = 1'b1;
                        w_aluOp     = ALU_PASS_DR;
                     end
                     OP_STA: begin
                        w_memWe  = 1'b1;
                        w_busSel = BUS_AC;
                     end
                     OP_BUN: begin
                        w_ld[LD_PC] = 1'b1;
                        w_busSel    = BUS_AR;
                     end
                     OP_BSA: begin
                        w_memWe  = 1'b1;
                        w_busSel = BUS_PC;
                        if (ctl.mem_ready) w_inc[INC_AR] = 1'b1;
                     end
                     OP_ISZ: w_inc[INC_DR] = 1'b1;
                     default: ;
                  endcase
               end
            end
            ST_EX2: begin
               case (w_opcode)
                  OP_BSA: begin
                     w_ld[LD_PC] = 1'b1;
                     w_busSel    = BUS_AR;
                  end
                  OP_ISZ: begin
                     w_memWe  = 1'b1;
                     w_busSel = BUS_DR;
                     if (ctl.mem_ready && ctl.dr_zero) w_inc[INC_PC] = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_HLT:  w_halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign ctl.mem_re  = w_memRe;
   assign ctl.mem_we  = w_memWe;
   assign ctl.ld      = w_ld;
   assign ctl.inc     = w_inc;
   assign ctl.clr_ac  = w_clrAc;
   assign ctl.bus_sel = w_busSel;
   assign ctl.alu_op  = w_aluOp;
   assign ctl.halted  = w_halted;

endmodule

// File: tb/tb_bc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_bc_control_unit
// Directed bench for bc_control_unit. Outputs are packed as
// {halted, mem_re, mem_we, ld[4:0], inc[3:0], clr_ac, bus_sel[2:0], alu_op[2:0]}
// and compared against hand-computed vectors once per clock, in the low phase.
// Honours BC_INDIRECT_EN for the indirect-address instruction.
// ---------------------------------------------------------------------------
module tb_bc_control_unit;

   logic clk;
   logic rst;
   int   testsRun = 0;
   int   testsFailed = 0;

   bc_control_unit_if #(.W(16)) ifc ();

   bc_control_unit #(.W(16), .AW(12)) dut (
      .clk (clk),
      .rst (rst),
      .ctl (ifc)
   );

   logic [18:0] observed;
   assign observed = {ifc.halted, ifc.mem_re, ifc.mem_we, ifc.ld, ifc.inc,
                      ifc.clr_ac, ifc.bus_sel, ifc.alu_op};

   logic [18:0] zeroV, f0V, f1ReadyV, f1WaitV, decV, rdReadyV, rdWaitV;

   // Free-running 10-unit clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [18:0] outVec(input logic h, input logic re, input logic we,
                                          input logic [4:0] ld, input logic [3:0] inc,
                                          input logic clr, input logic [2:0] bs,
                                          input logic [2:0] alu);
      return {h, re, we, ld, inc, clr, bs, alu};
   endfunction

   // Inputs change just after the falling edge and settle before the compare.
   task automatic applyStimulus(input logic rstV, input logic [15:0] irV,
                                input logic readyV, input logic [2:0] flags);
      @(negedge clk);
      rst           = rstV;
      ifc.ir        = irV;
      ifc.mem_ready = readyV;
      {ifc.ac_zero, ifc.ac_neg, ifc.dr_zero} = flags;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [18:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %05h expected %05h", tag, observed, expected);
      end
   endtask

   // F0, F1 (memory ready) and DEC of one instruction.
   task automatic runFetch(input string name, input logic [15:0] irV, input logic [2:0] flags);
      applyStimulus(1'b0, irV, 1'b1, flags);
      checkOutput({name, "_f0"}, f0V);
      applyStimulus(1'b0, irV, 1'b1, flags);
      checkOutput({name, "_f1"}, f1ReadyV);
      applyStimulus(1'b0, irV, 1'b1, flags);
      checkOutput({name, "_dec"}, decV);
   endtask

   initial begin
      zeroV    = outVec(0, 0, 0, 5'b00000, 4'b0000, 0, 3'd0, 3'd0);
      f0V      = outVec(0, 0, 0, 5'b00001, 4'b0000, 0, 3'd2, 3'd0);
      f1ReadyV = outVec(0, 1, 0, 5'b10000, 4'b0010, 0, 3'd7, 3'd0);
      f1WaitV  = outVec(0, 1, 0, 5'b00000, 4'b0000, 0, 3'd7, 3'd0);
      decV     = outVec(0, 0, 0, 5'b00001, 4'b0000, 0, 3'd5, 3'd0);
      rdReadyV = outVec(0, 1, 0, 5'b00100, 4'b0000, 0, 3'd7, 3'd0);
      rdWaitV  = outVec(0, 1, 0, 5'b00000, 4'b0000, 0, 3'd7, 3'd0);

      rst = 1'b1;
      ifc.ir = 16'h0000;
      ifc.mem_ready = 1'b0;
      ifc.ac_zero = 1'b0;
      ifc.ac_neg = 1'b0;
      ifc.dr_zero = 1'b0;

      // Held in reset with live inputs: everything quiet.
      applyStimulus(1'b1, 16'h1234, 1'b1, 3'b111);
      checkOutput("reset_a", zeroV);
      applyStimulus(1'b1, 16'h1234, 1'b1, 3'b000);
      checkOutput("reset_b", zeroV);

      // ADD direct, no stalls: F0 F1 DEC RD EX1.
      runFetch("add", 16'h1234, 3'b000);
      applyStimulus(1'b0, 16'h1234, 1'b1, 3'b000);
      checkOutput("add_rd", rdReadyV);
      applyStimulus(1'b0, 16'h1234, 1'b1, 3'b000);
      checkOutput("add_ex1", outVec(0, 0, 0, 5'b01000, 4'b0000, 0, 3'd0, 3'd1));

      // Same ADD with memory stalls; mem_ready outside memory states is ignored.
      applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
      checkOutput("stall_f0", f0V);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
         checkOutput("stall_f1_wait", f1WaitV);
      end
      applyStimulus(1'b0, 16'h1234, 1'b1, 3'b000);
      checkOutput("stall_f1_ready", f1ReadyV);
      applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
      checkOutput("stall_dec", decV);
      applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
      checkOutput("stall_rd_wait", rdWaitV);
      applyStimulus(1'b0, 16'h1234, 1'b1, 3'b000);
      checkOutput("stall_rd_ready", rdReadyV);
      applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
      checkOutput("stall_ex1", outVec(0, 0, 0, 5'b01000, 4'b0000, 0, 3'd0, 3'd1));

      // LDA and AND.
      runFetch("lda", 16'h2000, 3'b000);
      applyStimulus(1'b0, 16'h2000, 1'b1, 3'b000);
      checkOutput("lda_rd", rdReadyV);
      applyStimulus(1'b0, 16'h2000, 1'b1, 3'b000);
      checkOutput("lda_ex1", outVec(0, 0, 0, 5'b01000, 4'b0000, 0, 3'd0, 3'd2));
      runFetch("and", 16'h0ABC, 3'b000);
      applyStimulus(1'b0, 16'h0ABC, 1'b1, 3'b000);
      checkOutput("and_rd", rdReadyV);
      applyStimulus(1'b0, 16'h0ABC, 1'b1, 3'b010);
      checkOutput("and_ex1", outVec(0, 0, 0, 5'b01000, 4'b0000, 0, 3'd0, 3'd0));

      // ISZ with DR wrapping to zero: PC skip in EX2.
      runFetch("isz", 16'h6010, 3'b000);
      applyStimulus(1'b0, 16'h6010, 1'b1, 3'b000);
      checkOutput("isz_rd", rdReadyV);
      applyStimulus(1'b0, 16'h6010, 1'b1, 3'b000);
      checkOutput("isz_ex1", outVec(0, 0, 0, 5'b00000, 4'b0100, 0, 3'd0, 3'd0));
      applyStimulus(1'b0, 16'h6010, 1'b1, 3'b001);
      checkOutput("isz_ex2", outVec(0, 0, 1, 5'b00000, 4'b0010, 0, 3'd3, 3'd0));

      // ISZ with a write stall, then DR nonzero: no skip.
      runFetch("isz2", 16'h6010, 3'b000);
      applyStimulus(1'b0, 16'h6010, 1'b1, 3'b000);
      checkOutput("isz2_rd", rdReadyV);
      applyStimulus(1'b0, 16'h6010, 1'b1, 3'b000);
      checkOutput("isz2_ex1", outVec(0, 0, 0, 5'b00000, 4'b0100, 0, 3'd0, 3'd0));
      applyStimulus(1'b0, 16'h6010, 1'b0, 3'b001);
      checkOutput("isz2_ex2_wait", outVec(0, 0, 1, 5'b00000, 4'b0000, 0, 3'd3, 3'd0));
      applyStimulus(1'b0, 16'h6010, 1'b1, 3'b000);
      checkOutput("isz2_ex2_nz", outVec(0, 0, 1, 5'b00000, 4'b0000, 0, 3'd3, 3'd0));

      // STA with one wait cycle.
      runFetch("sta", 16'h3000, 3'b000);
      applyStimulus(1'b0, 16'h3000, 1'b0, 3'b000);
      checkOutput("sta_ex1_wait", outVec(0, 0, 1, 5'b00000, 4'b0000, 0, 3'd4, 3'd0));
      applyStimulus(1'b0, 16'h3000, 1'b1, 3'b000);
      checkOutput("sta_ex1_ready", outVec(0, 0, 1, 5'b00000, 4'b0000, 0, 3'd4, 3'd0));

      // BUN.
      runFetch("bun", 16'h4000, 3'b000);
      applyStimulus(1'b0, 16'h4000, 1'b1, 3'b000);
      checkOutput("bun_ex1", outVec(0, 0, 0, 5'b00010, 4'b0000, 0, 3'd1, 3'd0));

      // BSA with one wait cycle on the return-address write.
      runFetch("bsa", 16'h5000, 3'b000);
      applyStimulus(1'b0, 16'h5000, 1'b0, 3'b000);
      checkOutput("bsa_ex1_wait", outVec(0, 0, 1, 5'b00000, 4'b0000, 0, 3'd2, 3'd0));
      applyStimulus(1'b0, 16'h5000, 1'b1, 3'b000);
      checkOutput("bsa_ex1_ready", outVec(0, 0, 1, 5'b00000, 4'b0001, 0, 3'd2, 3'd0));
      applyStimulus(1'b0, 16'h5000, 1'b1, 3'b000);
      checkOutput("bsa_ex2", outVec(0, 0, 0, 5'b00010, 4'b0000, 0, 3'd1, 3'd0));

      // Register-reference instructions (flags = {ac_zero, ac_neg, dr_zero}).
      runFetch("cla", 16'h7060, 3'b000);
      applyStimulus(1'b0, 16'h7060, 1'b1, 3'b000);
      checkOutput("cla_prio_ex1", outVec(0, 0, 0, 5'b00000, 4'b0000, 1, 3'd0, 3'd0));
      runFetch("cma", 16'h7020, 3'b000);
      applyStimulus(1'b0, 16'h7020, 1'b1, 3'b000);
      checkOutput("cma_ex1", outVec(0, 0, 0, 5'b01000, 4'b0000, 0, 3'd0, 3'd3));
      runFetch("inc", 16'h7010, 3'b000);
      applyStimulus(1'b0, 16'h7010, 1'b1, 3'b000);
      checkOutput("inc_ex1", outVec(0, 0, 0, 5'b00000, 4'b1000, 0, 3'd0, 3'd0));
      runFetch("spa_pos", 16'h7008, 3'b000);
      applyStimulus(1'b0, 16'h7008, 1'b1, 3'b000);
      checkOutput("spa_pos_ex1", outVec(0, 0, 0, 5'b00000, 4'b0010, 0, 3'd0, 3'd0));
      runFetch("spa_neg", 16'h7008, 3'b010);
      applyStimulus(1'b0, 16'h7008, 1'b1, 3'b010);
      checkOutput("spa_neg_ex1", zeroV);
      runFetch("sna_neg", 16'h7004, 3'b010);
      applyStimulus(1'b0, 16'h7004, 1'b1, 3'b010);
      checkOutput("sna_neg_ex1", outVec(0, 0, 0, 5'b00000, 4'b0010, 0, 3'd0, 3'd0));
      runFetch("sza_zero", 16'h7002, 3'b100);
      applyStimulus(1'b0, 16'h7002, 1'b1, 3'b100);
      checkOutput("sza_zero_ex1", outVec(0, 0, 0, 5'b00000, 4'b0010, 0, 3'd0, 3'd0));
      runFetch("sza_nz", 16'h7003, 3'b000);
      applyStimulus(1'b0, 16'h7003, 1'b1, 3'b000);
      checkOutput("sza_nz_ex1", zeroV);
      runFetch("nop", 16'h7000, 3'b111);
      applyStimulus(1'b0, 16'h7000, 1'b1, 3'b111);
      checkOutput("nop_ex1", zeroV);
      runFetch("op7_ind", 16'hF041, 3'b000);
      applyStimulus(1'b0, 16'hF041, 1'b1, 3'b000);
      checkOutput("op7_ind_ex1", zeroV);

      // Indirect ADD: IND state only when the feature is built in.
      runFetch("ind_add", 16'h9100, 3'b000);
`ifdef BC_INDIRECT_EN
      applyStimulus(1'b0, 16'h9100, 1'b1, 3'b000);
      checkOutput("ind_add_ind", outVec(0, 1, 0, 5'b00001, 4'b0000, 0, 3'd7, 3'd0));
`endif
      applyStimulus(1'b0, 16'h9100, 1'b1, 3'b000);
      checkOutput("ind_add_rd", rdReadyV);
      applyStimulus(1'b0, 16'h9100, 1'b1, 3'b000);
      checkOutput("ind_add_ex1", outVec(0, 0, 0, 5'b01000, 4'b0000, 0, 3'd0, 3'd1));

      // Reset in the middle of a fetch stall aborts the instruction.
      applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
      checkOutput("abort_f0", f0V);
      applyStimulus(1'b0, 16'h1234, 1'b0, 3'b000);
      checkOutput("abort_f1_wait", f1WaitV);
      applyStimulus(1'b1, 16'h1234, 1'b0, 3'b000);
      checkOutput("abort_rst_a", zeroV);
      applyStimulus(1'b1, 16'h1234, 1'b1, 3'b000);
      checkOutput("abort_rst_b", zeroV);

      // HLT: halted for 20 cycles with no strobes, released by rst.
      runFetch("hlt", 16'h7001, 3'b000);
      applyStimulus(1'b0, 16'h7001, 1'b1, 3'b000);
      checkOutput("hlt_ex1", zeroV);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 16'h7001, 1'(i % 2), 3'(i));
         checkOutput("hlt_hold", outVec(1, 0, 0, 5'b00000, 4'b0000, 0, 3'd0, 3'd0));
      end
      applyStimulus(1'b1, 16'h7001, 1'b1, 3'b000);
      checkOutput("hlt_rst", zeroV);
      applyStimulus(1'b0, 16'h1234, 1'b1, 3'b000);
      checkOutput("post_hlt_f0", f0V);
      applyStimulus(1'b0, 16'h1234, 1'b1, 3'b000);
      checkOutput("post_hlt_f1", f1ReadyV);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
